// File: rtl/morse_encoder.sv
// -----------------------------------------------------------------------------
// morse_encoder
//
// Transmit side of the Morse path. One character code is accepted per
// valid/ready handshake. The code is looked up in an ITU Morse table and
// played out as a timed on/off keying signal for an LED or buzzer.
//
// Timing, in Morse units of UNIT_CYCLES clocks:
//   dot mark 1, dash mark 3, gap between elements 1, gap after a character 3,
//   word space 4 (together with the preceding character gap this gives the
//   standard 7-unit word gap).
//
// Parameters
//   UNIT_CYCLES  clock cycles per Morse time unit (must be >= 2)
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   reset      in   synchronous, active-high reset
//   in_valid   in   char_code is valid this cycle
//   char_code  in   0-25 'A'-'Z', 26-35 '0'-'9', 36 word space, 37-63 invalid
//   in_ready   out  block can accept a code this cycle
//   tone       out  keying output, 1 = mark, 0 = silence (registered)
//   busy       out  a character or word space is in progress
//   done       out  one-cycle pulse on the final cycle of a character/space
//   err        out  one-cycle pulse the cycle after an invalid code is accepted
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module morse_encoder #(
  parameter int UNIT_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [5:0] char_code,
  output logic       in_ready,
  output logic       tone,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // The longest interval is the 4-unit word space; the counter holds
  // "cycles remaining minus one", so it must reach 4*UNIT_CYCLES-1.
  localparam int CNT_W = $clog2(4 * UNIT_CYCLES);

  localparam logic [CNT_W-1:0] DOT_LAST   = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LAST  = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CGAP_LAST  = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SPACE_LAST = CNT_W'(4 * UNIT_CYCLES - 1);

  localparam logic [5:0] LAST_CHAR_CODE = 6'd35;
  localparam logic [5:0] SPACE_CODE     = 6'd36;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_GAP,
    S_CHAR_GAP,
    S_SPACE
  } state_t;

  // ---------------------------------------------------------------------------
  // Morse table: {len[2:0], pat[4:0]}. The pattern is right-aligned and sent
  // MSB-first, i.e. element i of a len-element character lives in
  // pat[len-1-i]; 1 = dash, 0 = dot. Invalid codes return len 0.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] morse_rom(input logic [5:0] code);
    logic [7:0] v;
    v = 8'd0;
    case (code)
      6'd0:  v = {3'd2, 5'b00001}; // A .-
      6'd1:  v = {3'd4, 5'b01000}; // B -...
      6'd2:  v = {3'd4, 5'b01010}; // C -.-.
      6'd3:  v = {3'd3, 5'b00100}; // D -..
      6'd4:  v = {3'd1, 5'b00000}; // E .
      6'd5:  v = {3'd4, 5'b00010}; // F ..-.
      6'd6:  v = {3'd3, 5'b00110}; // G --.
      6'd7:  v = {3'd4, 5'b00000}; // H ....
      6'd8:  v = {3'd2, 5'b00000}; // I ..
      6'd9:  v = {3'd4, 5'b00111}; // J .---
      6'd10: v = {3'd3, 5'b00101}; // K -.-
      6'd11: v = {3'd4, 5'b00100}; // L .-..
      6'd12: v = {3'd2, 5'b00011}; // M --
      6'd13: v = {3'd2, 5'b00010}; // N -.
      6'd14: v = {3'd3, 5'b00111}; // O ---
      6'd15: v = {3'd4, 5'b00110}; // P .--.
      6'd16: v = {3'd4, 5'b01101}; // Q --.-
      6'd17: v = {3'd3, 5'b00010}; // R .-.
      6'd18: v = {3'd3, 5'b00000}; // S ...
      6'd19: v = {3'd1, 5'b00001}; // T -
      6'd20: v = {3'd3, 5'b00001}; // U ..-
      6'd21: v = {3'd4, 5'b00001}; // V ...-
      6'd22: v = {3'd3, 5'b00011}; // W .--
      6'd23: v = {3'd4, 5'b01001}; // X -..-
      6'd24: v = {3'd4, 5'b01011}; // Y -.--
      6'd25: v = {3'd4, 5'b01100}; // Z --..
      6'd26: v = {3'd5, 5'b11111}; // 0 -----
      6'd27: v = {3'd5, 5'b01111}; // 1 .----
      6'd28: v = {3'd5, 5'b00111}; // 2 ..---
      6'd29: v = {3'd5, 5'b00011}; // 3 ...--
      6'd30: v = {3'd5, 5'b00001}; // 4 ....-
      6'd31: v = {3'd5, 5'b00000}; // 5 .....
      6'd32: v = {3'd5, 5'b10000}; // 6 -....
      6'd33: v = {3'd5, 5'b11000}; // 7 --...
      6'd34: v = {3'd5, 5'b11100}; // 8 ---..
      6'd35: v = {3'd5, 5'b11110}; // 9 ----.
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;    // cycles remaining in current interval, minus one
  logic [2:0]       r_idx;    // index into r_pat of the current element
  logic [4:0]       r_pat;    // latched pattern of the character being sent
  logic             r_tone;
  logic             r_done;
  logic             r_err;

  // ---------------------------------------------------------------------------
  // Table lookup on the incoming code
  // ---------------------------------------------------------------------------
  logic [7:0] w_rom;
  logic [2:0] w_len;
  logic [4:0] w_pat;
  logic [2:0] w_first_idx;
  logic       w_first_dash;
  logic       w_is_char;
  logic       w_is_space;
  logic       w_accept;

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_rom        = morse_rom(char_code);
    w_len        = w_rom[7:5];
    w_pat        = w_rom[4:0];
    w_first_idx  = 3'd0;
    w_first_dash = 1'b0;
    if (w_len != 3'd0) begin
      w_first_idx  = w_len - 3'd1;
      w_first_dash = w_pat[w_first_idx];
    end
  end

  assign w_is_char  = (char_code <= LAST_CHAR_CODE);
  assign w_is_space = (char_code == SPACE_CODE);
  assign w_accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Sequencer. tone/done/err are registered here so the keying line is
  // glitch-free and the pulses line up exactly with the state they describe.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_pat   <= '0;
      r_tone  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // Pulses default low; at most one branch below raises one of them.
      r_done <= 1'b0;
      r_err  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_char) begin
              r_state <= S_MARK;
              r_pat   <= w_pat;
              r_idx   <= w_first_idx;
              r_cnt   <= w_first_dash ? DASH_LAST : DOT_LAST;
              r_tone  <= 1'b1;
            end else if (w_is_space) begin
              r_state <= S_SPACE;
              r_cnt   <= SPACE_LAST;
            end else begin
              // Invalid code: consumed, flagged, nothing transmitted.
              r_err <= 1'b1;
            end
          end
        end

        S_MARK: begin
          if (r_cnt == '0) begin
            r_tone <= 1'b0;
            if (r_idx == 3'd0) begin
              r_state <= S_CHAR_GAP;
              r_cnt   <= CGAP_LAST;
            end else begin
              r_state <= S_GAP;
              r_cnt   <= GAP_LAST;
              r_idx   <= r_idx - 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_GAP: begin
          // r_idx already points at the next element to send.
          if (r_cnt == '0) begin
            r_state <= S_MARK;
            r_tone  <= 1'b1;
            r_cnt   <= r_pat[r_idx] ? DASH_LAST : DOT_LAST;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_CHAR_GAP, S_SPACE: begin
          // done is raised one edge early so it is visible on the final
          // cycle of the interval; UNIT_CYCLES >= 2 guarantees r_cnt passes 1.
          if (r_cnt == CNT_W'(1)) begin
            r_done <= 1'b1;
          end
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tone  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready = (r_state == S_IDLE) && !reset;
  assign busy     = (r_state != S_IDLE);
  assign tone     = r_tone;
  assign done     = r_done;
  assign err      = r_err;

endmodule
